// File: rtl/mips_multicycle_ctrl_if.sv
// Control-sequencer bundle between the multi-cycle MIPS controller, the datapath and memory.
// The master modport is the controller; the slave modport is the datapath/memory side.
interface mips_multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_source;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic [3:0]       state;
    logic             retire;
    logic [CNT_W-1:0] retired_count;
    logic             illegal;

    modport master (
        input  opcode, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
        output alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
        output state, retire, retired_count, illegal
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
        input  alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
        input  state, retire, retired_count, illegal
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control sequencer for the multi-cycle MIPS datapath: fetch/decode/execute/mem/write-back
// with a variable-latency memory handshake, a retired-instruction counter and a sticky illegal flag.
module mips_multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    mips_multicycle_ctrl_if.master  ctrl_io
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRtEx   = 4'd6,
        StRtWb   = 4'd7,
        StBeq    = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11,
        StHalt   = 4'd12
    } state_e;

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    state_e           state_q, state_d;
    logic             is_store_q, is_store_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;

    // Strobes are decoded from the current state; reset overrides everything to idle.
    always_comb begin
        ctrl_io.mem_read      = 1'b0;
        ctrl_io.mem_write     = 1'b0;
        ctrl_io.i_or_d        = 1'b0;
        ctrl_io.ir_write      = 1'b0;
        ctrl_io.pc_write      = 1'b0;
        ctrl_io.pc_write_cond = 1'b0;
        ctrl_io.pc_source     = 2'd0;
        ctrl_io.alu_src_a     = 1'b0;
        ctrl_io.alu_src_b     = 2'd0;
        ctrl_io.alu_op        = 2'd0;
        ctrl_io.reg_write     = 1'b0;
        ctrl_io.reg_dst       = 1'b0;
        ctrl_io.mem_to_reg    = 1'b0;
        retire                = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                StFetch: begin
                    ctrl_io.mem_read  = 1'b1;
                    ctrl_io.alu_src_b = 2'd1;
                    ctrl_io.ir_write  = ctrl_io.mem_ready;
                    ctrl_io.pc_write  = ctrl_io.mem_ready;
                end
                StDecode: begin
                    // Branch target precompute: PC + (imm << 2).
                    ctrl_io.alu_src_b = 2'd3;
                end
                StMemAdr: begin
                    ctrl_io.alu_src_a = 1'b1;
                    ctrl_io.alu_src_b = 2'd2;
                end
                StMemRd: begin
                    ctrl_io.mem_read = 1'b1;
                    ctrl_io.i_or_d   = 1'b1;
                end
                StMemWb: begin
                    ctrl_io.reg_write  = 1'b1;
                    ctrl_io.mem_to_reg = 1'b1;
                    retire             = 1'b1;
                end
                StMemWr: begin
                    ctrl_io.mem_write = 1'b1;
                    ctrl_io.i_or_d    = 1'b1;
                    retire            = ctrl_io.mem_ready;
                end
                StRtEx: begin
                    ctrl_io.alu_src_a = 1'b1;
                    ctrl_io.alu_op    = 2'd2;
                end
                StRtWb: begin
                    ctrl_io.reg_write = 1'b1;
                    ctrl_io.reg_dst   = 1'b1;
                    retire            = 1'b1;
                end
                StBeq: begin
                    ctrl_io.alu_src_a     = 1'b1;
                    ctrl_io.alu_op        = 2'd1;
                    ctrl_io.pc_write_cond = 1'b1;
                    ctrl_io.pc_source     = 2'd1;
                    retire                = 1'b1;
                end
                StAddiEx: begin
                    ctrl_io.alu_src_a = 1'b1;
                    ctrl_io.alu_src_b = 2'd2;
                end
                StAddiWb: begin
                    ctrl_io.reg_write = 1'b1;
                    retire            = 1'b1;
                end
                StJump: begin
                    ctrl_io.pc_write  = 1'b1;
                    ctrl_io.pc_source = 2'd2;
                    retire            = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ctrl_io.retire        = retire;
    assign ctrl_io.state         = state_q;
    assign ctrl_io.illegal       = illegal_q;
    assign ctrl_io.retired_count = count_q;

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        illegal_d  = illegal_q;
        count_d    = count_q;
        unique case (state_q)
            StFetch:  if (ctrl_io.mem_ready) state_d = StDecode;
            StDecode: begin
                // Remember load vs store so MEMADR does not depend on the IR staying put.
                is_store_d = (ctrl_io.opcode == OpSw);
                case (ctrl_io.opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRType:    state_d = StRtEx;
                    OpBeq:      state_d = StBeq;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default: begin
                        state_d   = StHalt;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: state_d = is_store_q ? StMemWr : StMemRd;
            StMemRd:  if (ctrl_io.mem_ready) state_d = StMemWb;
            StMemWr:  if (ctrl_io.mem_ready) state_d = StFetch;
            StRtEx:   state_d = StRtWb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StRtWb, StBeq, StAddiWb, StJump: state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
        if (retire) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StFetch;
            is_store_q <= 1'b0;
            illegal_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            illegal_q  <= illegal_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized scoreboard bench for mips_multicycle_ctrl plus directed halt, reset and lw cases.
module tb_mips_multicycle_ctrl;

    localparam int unsigned CntW     = 4;
    localparam int unsigned NumInstr = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.CNT_W(CntW)) bus ();
    mips_multicycle_ctrl #(.CNT_W(CntW)) dut (.clk_i(clk), .rst_i(rst), .ctrl_io(bus));

    typedef struct {
        int          cycles;
        logic [3:0]  state;
        logic [15:0] vec;
        logic [CntW-1:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [5:0] op_q[$];
    int         wait_q[$];
    int         checks = 0;
    int         errors = 0;
    int         phase = 0;
    bit         have_wait = 1'b0;
    int         cur_wait = 0;
    logic [5:0] legal_ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    int         lw_seq [9] = '{0, 0, 0, 1, 2, 3, 3, 3, 4};

    function automatic logic [15:0] mk(bit mr, bit mw, bit iod, bit irw, bit pw, bit pwc,
                                       logic [1:0] ps, bit asa, logic [1:0] asb,
                                       logic [1:0] aop, bit rw, bit rd, bit m2r);
        return {mr, mw, iod, irw, pw, pwc, ps, asa, asb, aop, rw, rd, m2r};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write,
                bus.pc_write_cond, bus.pc_source, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each instruction should look like in its retire cycle.
    function automatic exp_t model(logic [5:0] op, int wf, int wm, int idx);
        exp_t e;
        e.cnt = idx[CntW-1:0];
        case (op)
            6'h00: begin
                e.cycles = 4 + wf; e.state = 4'd7;
                e.vec = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0,
                           1'b1, 1'b1, 1'b0);
            end
            6'h23: begin
                e.cycles = 5 + wf + wm; e.state = 4'd4;
                e.vec = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0,
                           1'b1, 1'b0, 1'b1);
            end
            6'h2B: begin
                e.cycles = 4 + wf + wm; e.state = 4'd5;
                e.vec = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0,
                           1'b0, 1'b0, 1'b0);
            end
            6'h04: begin
                e.cycles = 3 + wf; e.state = 4'd8;
                e.vec = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 2'd1,
                           1'b0, 1'b0, 1'b0);
            end
            6'h08: begin
                e.cycles = 4 + wf; e.state = 4'd10;
                e.vec = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0,
                           1'b1, 1'b0, 1'b0);
            end
            default: begin
                e.cycles = 3 + wf; e.state = 4'd11;
                e.vec = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 2'd0,
                           1'b0, 1'b0, 1'b0);
            end
        endcase
        return e;
    endfunction

    // Memory responder and IR emulation; runs a little after the falling edge.
    task automatic respond();
        #1;
        if (bus.mem_read || bus.mem_write) begin
            if (!have_wait) begin
                cur_wait  = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
                have_wait = 1'b1;
            end
            if (cur_wait > 0) begin
                bus.mem_ready = 1'b0;
                cur_wait--;
            end else begin
                bus.mem_ready = 1'b1;
                have_wait     = 1'b0;
            end
        end else begin
            bus.mem_ready = 1'($urandom_range(0, 1));
        end
        #1;
        if (bus.ir_write) bus.opcode = (op_q.size() > 0) ? op_q.pop_front() : 6'h3F;
    endtask

    task automatic step();
        @(negedge clk);
        respond();
    endtask

    // Monitor: per-cycle invariants and scoreboard pop on every retire pulse.
    initial begin
        int   cyc = 0;
        int   irw = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (phase == 1 && !rst) begin
                cyc++;
                if (bus.ir_write) irw++;
                chk("mem_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
                if (bus.state == 4'd0)
                    chk("fetch_vec", 32'(dut_vec()),
                        32'(mk(1'b1, 1'b0, 1'b0, bus.mem_ready, bus.mem_ready, 1'b0, 2'd0,
                               1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0)));
                else if (bus.state == 4'd1)
                    chk("decode_vec", 32'(dut_vec()),
                        32'(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd3, 2'd0,
                               1'b0, 1'b0, 1'b0)));
                if (bus.retire) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_retire", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("instr_cycles", 32'(cyc), 32'(e.cycles));
                        chk("retire_state", 32'(bus.state), 32'(e.state));
                        chk("retire_vec", 32'(dut_vec()), 32'(e.vec));
                        chk("count_before", 32'(bus.retired_count), 32'(e.cnt));
                        chk("ir_write_once", 32'(irw), 32'd1);
                    end
                    cyc = 0;
                    irw = 0;
                end
            end else begin
                cyc = 0;
                irw = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        int         wf;
        int         wm;
        rst           = 1'b1;
        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b0;

        for (int i = 0; i < int'(NumInstr); i++) begin
            op = legal_ops[$urandom_range(0, 5)];
            wf = $urandom_range(0, 3);
            wm = (op == 6'h23 || op == 6'h2B) ? $urandom_range(0, 3) : 0;
            op_q.push_back(op);
            wait_q.push_back(wf);
            if (op == 6'h23 || op == 6'h2B) wait_q.push_back(wm);
            exp_q.push_back(model(op, wf, wm, i));
        end

        repeat (3) @(negedge clk);
        #1;
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_count", 32'(bus.retired_count), 32'd0);
        chk("reset_illegal", 32'(bus.illegal), 32'd0);
        chk("reset_strobes", 32'({dut_vec(), bus.retire}), 32'd0);

        // Random program against the scoreboard.
        phase = 1;
        @(negedge clk);
        rst = 1'b0;
        respond();
        for (int k = 0; k < 3000 && exp_q.size() > 0; k++) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        phase = 2;
        chk("count_wrapped", 32'(bus.retired_count), 32'(NumInstr % (1 << CntW)));

        // Program exhausted: the IR now holds 0x3F, which must halt.
        for (int k = 0; k < 30 && bus.state != 4'd12; k++) step();
        chk("halt_reached", 32'(bus.state), 32'd12);
        repeat (10) begin
            step();
            chk("halt_state", 32'(bus.state), 32'd12);
            chk("halt_illegal", 32'(bus.illegal), 32'd1);
            chk("halt_strobes", 32'({dut_vec(), bus.retire}), 32'd0);
            chk("halt_count", 32'(bus.retired_count), 32'(NumInstr % (1 << CntW)));
        end

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_forces_idle", 32'({dut_vec(), bus.retire}), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_halt_state", 32'(bus.state), 32'd0);
        chk("rst_halt_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_halt_count", 32'(bus.retired_count), 32'd0);

        // Reset while a store is waiting in MEMWR with ready high.
        op_q.delete();
        wait_q.delete();
        have_wait = 1'b0;
        op_q.push_back(6'h2B);
        wait_q.push_back(0);
        wait_q.push_back(5);
        @(negedge clk);
        rst = 1'b0;
        respond();
        for (int k = 0; k < 40 && bus.state != 4'd5; k++) step();
        chk("memwr_reached", 32'(bus.state), 32'd5);
        @(negedge clk);
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        chk("memwr_rst_write", 32'(bus.mem_write), 32'd0);
        chk("memwr_rst_retire", 32'(bus.retire), 32'd0);
        @(negedge clk);
        #1;
        chk("memwr_rst_state", 32'(bus.state), 32'd0);
        chk("memwr_rst_count", 32'(bus.retired_count), 32'd0);

        // Directed lw with two wait cycles in both FETCH and MEMRD.
        op_q.delete();
        wait_q.delete();
        have_wait = 1'b0;
        op_q.push_back(6'h23);
        wait_q.push_back(2);
        wait_q.push_back(2);
        for (int k = 0; k < 9; k++) begin
            if (k == 0) begin
                @(negedge clk);
                rst = 1'b0;
                respond();
            end else begin
                step();
            end
            #1;
            chk("lw_state_seq", 32'(bus.state), 32'(lw_seq[k]));
            chk("lw_ir_write", 32'(bus.ir_write), (k == 2) ? 32'd1 : 32'd0);
        end
        chk("lw_mem_to_reg", 32'({bus.reg_write, bus.reg_dst, bus.mem_to_reg}), 32'b101);
        chk("lw_retire", 32'(bus.retire), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control sequencer for the multi-cycle MIPS datapath. It walks each instruction through fetch, decode, execute, memory and write-back. It drives every datapath strobe and mux select: PC, IR, memory port, register file write port, and ALU. It also handshakes with a variable-latency unified memory and keeps a retired-instruction count. It sits beside the instruction decode stage, takes `opcode` from it, and returns `reg_write`/`reg_dst`/`mem_to_reg` to it.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  instr[31:26] from the instruction register.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `mem_read`, `mem_write`  out  1  memory request strobes, held until `mem_ready`.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load the IR.
- `pc_write`, `pc_write_cond`  out  1  unconditional PC load; PC load qualified by ALU zero.
- `pc_source`  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- `alu_src_a`  out  1  0 = PC, 1 = regOut1.
- `alu_src_b`  out  2  0 = regOut2, 1 = const 4, 2 = immValue, 3 = immValue<<2.
- `alu_op`  out  2  0 = add, 1 = sub, 2 = use funct.
- `reg_write`, `reg_dst`, `mem_to_reg`  out  1  register-file write enable; 0 = rt / 1 = rd; 0 = ALUOut / 1 = MDR.
- `state`  out  4  current state encoding, for debug.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `retired_count`  out  CNT_W  number of retired instructions, wraps modulo 2^CNT_W.
- `illegal`  out  1  sticky; unsupported opcode decoded.

## Operation
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
  - RTEX=6, RTWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=12.
- FETCH:
  - Asserts `mem_read`, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - Stays in FETCH while `mem_ready`=0.
  - In the cycle `mem_ready`=1, also asserts `ir_write` and `pc_write`, then goes to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute).
  - Next state by opcode: 0x23/0x2B → MEMADR; 0x00 → RTEX; 0x04 → BEQ; 0x08 → ADDIEX; 0x02 → JUMP; any other → HALT.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0. Goes to MEMRD for 0x23, MEMWR for 0x2B.
- MEMRD: `mem_read`, i_or_d=1. Waits on `mem_ready`, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, retire. Goes to FETCH.
- MEMWR: `mem_write`, i_or_d=1. Waits on `mem_ready`; retires in the ready cycle, then goes to FETCH.
- RTEX: alu_src_a=1, alu_src_b=0, alu_op=2. Goes to RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0, retire. Goes to FETCH.
- BEQ: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1, retire. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=0. Goes to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, retire. Goes to FETCH.
- JUMP: pc_write=1, pc_source=2, retire. Goes to FETCH.
- HALT: sets `illegal`; all strobes 0; stays in HALT until `rst`.
- Any strobe or select not listed for a state is 0.
- `retired_count` increments by 1 on the edge ending each cycle in which `retire`=1; it wraps from all-ones to 0.
- `mem_ready` is ignored in every state that does not access memory.

## Timing
- Outputs are combinational from `state`, plus `mem_ready` for `ir_write`/`pc_write`/`retire` in FETCH and MEMWR.
- While `rst`=1, all strobes are forced to 0, whatever the state.
- At the `rst` edge: state=FETCH, `retired_count`=0, `illegal`=0.
- Reset mid-instruction abandons that instruction with no retire. FETCH starts in the first cycle after `rst` falls.
- Cycles per instruction with `mem_ready` tied to 1: j 3, beq 3, R-type 4, addi 4, sw 4, lw 5.
- Each wait cycle at `mem_ready`=0 adds one cycle to the instruction.
- Memory strobes stay stable while waiting: no deassertion and no change of `i_or_d`.
- At most one of `mem_read`/`mem_write` is high in any cycle.

## Test plan
- Reset then R-type (0x00), `mem_ready`=1: states 0,1,6,7,0. `reg_write`=1 with `reg_dst`=1 in cycle 4. `retired_count`=1.
- lw (0x23) with `mem_ready` low for 2 cycles in both FETCH and MEMRD: states 0,0,0,1,2,3,3,3,4. `ir_write` pulses only in the third FETCH cycle. `mem_to_reg`=1 in MEMWB.
- Sequence beq, j, sw, addi, `mem_ready`=1: per-instruction cycles 3,3,4,4. `retire` pulses 4 times; `pc_write_cond` only in BEQ; `pc_source`=2 only in JUMP.
- Opcode 0x3F: DECODE → HALT; `illegal`=1 and all strobes 0 for 10+ cycles. `rst` clears `illegal` and returns to FETCH.
- Assert `rst` in MEMWR with `mem_ready`=1: no retire, `mem_write`=0 during reset, state=0 and count unchanged at 0 after the edge.
- With CNT_W=4, retire 17 R-type instructions: `retired_count` wraps 15 → 0 and ends at 1.
